mtr_drv: RTL and testbench
==========================

MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 Parameter DEAD_TIME, default 32: dead-time clocks between complementary PWM edges (valid range 1..255).
REQ-002 Parameter BLANK, default 128: clocks after a PWM rising edge during which overcurrent is ignored.
REQ-003 Parameter OVR_LIM, default 4: number of consecutive faulted PWM periods that triggers shutdown.
REQ-004 clk  input  1  system clock, 50MHz; one clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 lft_spd  input  12  signed left motor speed from the stage-2 SegwayMath output.
REQ-007 rght_spd  input  12  signed right motor speed from the stage-2 SegwayMath output.
REQ-008 spd_vld  input  1  one-clock pulse; lft_spd/rght_spd are valid this cycle.
REQ-009 OVR_I_lft, OVR_I_rght  input  1 each  overcurrent flags from the bridge drivers, already synchronized.
REQ-010 lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2  output  1 each  registered complementary high-side/low-side gate drives.
REQ-011 OVR_I_shtdwn  output  1  registered, sticky overcurrent shutdown indication.

Function
REQ-012 Free-running 11-bit period counter cnt SHALL count 0..2047 and wrap to 0; one PWM period is 2048 clocks.
REQ-013 On spd_vld, shadow registers SHALL capture lft_spd and rght_spd; spd_vld pulses on consecutive clocks SHALL cause the last value to win.
REQ-014 When cnt==2047, each motor's duty SHALL load from its shadow as sat(spd+1024) clipped to 0..2047, computed at 13-bit signed width; duty SHALL never change mid-period.
REQ-015 For each motor, PWM2 SHALL rise when cnt==DEAD_TIME and fall when cnt==duty; if duty<=DEAD_TIME, PWM2 SHALL stay low the whole period.
REQ-016 For each motor, PWM1 SHALL rise when cnt==duty+DEAD_TIME and fall when cnt wraps to 0; if duty+DEAD_TIME>2047, PWM1 SHALL stay low the whole period.
REQ-017 PWM1 and PWM2 of the same motor SHALL never be high in the same cycle, and each falling edge SHALL be separated from the opposite rising edge by at least DEAD_TIME clocks.
REQ-018 A motor's overcurrent flag SHALL count as a period fault only while either of that motor's PWMs is high, and at least BLANK clocks after that PWM's rising edge.
REQ-019 A per-period fault bit SHALL be the OR of both motors' qualified flags; at cnt==2047, the consecutive-fault counter SHALL increment if the fault bit is set (saturating at OVR_LIM), clear if it is not, and the fault bit SHALL then clear.
REQ-020 FSM states SHALL be IDLE, RUN and SHTDWN.
REQ-021 IDLE -> RUN at the first cnt==2047 after at least one spd_vld has been seen.
REQ-022 RUN -> SHTDWN when the consecutive-fault counter reaches OVR_LIM.
REQ-023 SHTDWN SHALL be exited only by rst.
REQ-024 In IDLE and SHTDWN, all four PWM outputs SHALL be low; OVR_I_shtdwn SHALL be high only in SHTDWN.
REQ-025 The shutdown transition SHALL drive the PWMs low on the next clock, regardless of cnt.
REQ-026 Latency from spd_vld to the new duty taking effect SHALL be at most one full period plus one clock.

Reset
REQ-027 On rst, all of the following SHALL clear: cnt, shadows, duties (to 1024), fault counter, fault bit, spd_vld-seen flag, FSM (to IDLE), all PWM outputs, and OVR_I_shtdwn.
REQ-028 An rst asserted mid-period or in SHTDWN SHALL take effect on the next clock edge with no partial-period output.

Structure
REQ-029 Package mtr_drv_pkg SHALL hold the state enum typedef, PWM_MAX=2047, and DUTY_MID=1024.
REQ-030 A sub-module pwm_dt SHALL hold the duty register, edge generation and the qualified-overcurrent output; it SHALL be instantiated once per motor, sharing cnt.

Verification
REQ-031 rst, spd_vld with lft=0, rght=0 -> from the first RUN period, PWM2 high for cnt 32..1023 and PWM1 high for cnt 1056..2047, on both motors.
REQ-032 lft=+1200 (saturates to 2047), rght=-1100 (saturates to 0) -> lft_PWM1 never high, lft_PWM2 high for 32..2046; rght_PWM2 never high, rght_PWM1 high for 32..2047.
REQ-033 spd_vld mid-period with a new value -> the current period is unchanged and the new duty is applied at the next wrap; the "PWMs never both high" assertion holds throughout.
REQ-034 OVR_I_lft held high in 4 consecutive periods beyond blanking -> OVR_I_shtdwn=1 and all PWMs low one clock after the 4th cnt==2047; a 3-period burst followed by a clean period does not trigger shutdown.
REQ-035 OVR_I_rght pulsed only within 128 clocks of each PWM rising edge -> no fault is counted, ever.
REQ-036 rst asserted in SHTDWN and mid-period -> next cycle IDLE, all outputs 0, cnt=0.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mtr_drv_pkg
// Brief   : Shared state type, PWM constants and duty saturation helper for
//           the dual-motor dead-time PWM driver.
// Rev     : 1.0  initial release
// ============================================================================
package mtr_drv_pkg;

    localparam logic [10:0] PWM_MAX  = 11'd2047;
    localparam logic [10:0] DUTY_MID = 11'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SHTDWN = 2'd2
    } state_t;

    // Signed speed offset to mid-scale, clipped into the 0..2047 duty range
    function automatic logic [10:0] sat_duty(input logic signed [11:0] spd);
        logic signed [12:0] sum;
        sum = $signed({spd[11], spd}) + 13'sd1024;
        if (sum < 13'sd0)
            sat_duty = 11'd0;
        else if (sum > 13'sd2047)
            sat_duty = PWM_MAX;
        else
            sat_duty = sum[10:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_drv_if.sv
`default_nettype none
// ============================================================================
// Module  : mtr_drv_if
// Brief   : Speed command, overcurrent flags and gate-drive outputs of the
//           motor driver bundled as one interface.
// Rev     : 1.0  initial release
// ============================================================================
interface mtr_drv_if;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               spd_vld;
    logic               OVR_I_lft;
    logic               OVR_I_rght;
    logic               lft_PWM1;
    logic               lft_PWM2;
    logic               rght_PWM1;
    logic               rght_PWM2;
    logic               OVR_I_shtdwn;

    modport master (
        output lft_spd, rght_spd, spd_vld, OVR_I_lft, OVR_I_rght,
        input  lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, OVR_I_shtdwn
    );

    modport slave (
        input  lft_spd, rght_spd, spd_vld, OVR_I_lft, OVR_I_rght,
        output lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, OVR_I_shtdwn
    );
endinterface
`default_nettype wire

// File: rtl/mtr_drv_pwm_dt.sv
`default_nettype none
// ============================================================================
// Module  : pwm_dt
// Brief   : One motor's duty register, complementary dead-time PWM edges and
//           blanked overcurrent qualification.
// Rev     : 1.0  initial release
// ============================================================================
module pwm_dt #(
    parameter int DEAD_TIME = 32,
    parameter int BLANK     = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cnt,
    input  logic        load,
    input  logic [10:0] duty_in,
    input  logic        en,
    input  logic        ovr_i,
    output logic        pwm1,
    output logic        pwm2,
    output logic        ovr_qual
);
    import mtr_drv_pkg::*;

    localparam logic [13:0] c_dt    = 14'(DEAD_TIME);
    localparam logic [13:0] c_blank = 14'(BLANK);

    logic [10:0] r_duty;
    logic        r_pwm1;
    logic        r_pwm2;
    logic [13:0] w_cnt_ext;
    logic [13:0] w_nxt_ext;
    logic [13:0] w_rise1;
    logic        w_on1;
    logic        w_on2;

    // Decide the levels for the upcoming count so the registered outputs line
    // up with cnt; a wrap (next count 0) always lands with both sides low.
    always_comb begin
        w_cnt_ext = {3'b000, cnt};
        w_nxt_ext = {3'b000, cnt + 11'd1};
        w_rise1   = {3'b000, r_duty} + c_dt;
        w_on2     = (w_nxt_ext >= c_dt) && (w_nxt_ext < {3'b000, r_duty});
        w_on1     = (w_nxt_ext >= w_rise1);
        ovr_qual  = ovr_i &&
                    ((r_pwm2 && (w_cnt_ext >= c_dt + c_blank)) ||
                     (r_pwm1 && (w_cnt_ext >= w_rise1 + c_blank)));
    end

    // Duty only changes at the period boundary; outputs forced low unless running
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= DUTY_MID;
            r_pwm1 <= 1'b0;
            r_pwm2 <= 1'b0;
        end else begin
            if (load)
                r_duty <= duty_in;
            r_pwm1 <= en && w_on1;
            r_pwm2 <= en && w_on2;
        end
    end

    assign pwm1 = r_pwm1;
    assign pwm2 = r_pwm2;

endmodule
`default_nettype wire

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
// Module  : mtr_drv
// Brief   : Dual-motor complementary PWM driver with dead time, speed shadow
//           registers and consecutive-period overcurrent shutdown.
// Rev     : 1.0  initial release
// ============================================================================
module mtr_drv #(
    parameter int DEAD_TIME = 32,
    parameter int BLANK     = 128,
    parameter int OVR_LIM   = 4
) (
    input  logic     clk,
    input  logic     rst,
    mtr_drv_if.slave bus
);
    import mtr_drv_pkg::*;

    localparam logic [7:0] c_lim = 8'(OVR_LIM);

    logic [10:0]        r_cnt;
    logic signed [11:0] r_lft_shd;
    logic signed [11:0] r_rght_shd;
    logic               r_seen;
    logic               r_fault;
    logic               r_shtdwn;
    logic [7:0]         r_fcnt;
    logic [7:0]         w_fcnt_nxt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_wrap;
    logic               w_seen;
    logic               w_fault_now;
    logic               w_run_nxt;
    logic               w_lft_q;
    logic               w_rght_q;
    logic [10:0]        w_lft_duty;
    logic [10:0]        w_rght_duty;

    // Period bookkeeping: a speed arriving on the wrap cycle itself is used
    // directly so the command-to-output latency stays within one period.
    always_comb begin
        w_wrap      = (r_cnt == PWM_MAX);
        w_seen      = r_seen | bus.spd_vld;
        w_lft_duty  = sat_duty(bus.spd_vld ? bus.lft_spd  : r_lft_shd);
        w_rght_duty = sat_duty(bus.spd_vld ? bus.rght_spd : r_rght_shd);
        w_fault_now = r_fault | w_lft_q | w_rght_q;
        w_fcnt_nxt  = r_fcnt;
        if (w_wrap) begin
            if (!w_fault_now)
                w_fcnt_nxt = 8'd0;
            else if (r_fcnt < c_lim)
                w_fcnt_nxt = r_fcnt + 8'd1;
        end
    end

    // Next-state logic; shutdown is taken on the same wrap that completes the
    // last faulted period so the gates drop on the following clock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_wrap && w_seen)        w_state_nxt = RUN;
            RUN:     if (w_fcnt_nxt >= c_lim)     w_state_nxt = SHTDWN;
            SHTDWN:                               w_state_nxt = SHTDWN;
            default:                              w_state_nxt = IDLE;
        endcase
        w_run_nxt = (w_state_nxt == RUN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Period counter, speed shadows and fault history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 11'd0;
            r_lft_shd  <= 12'sd0;
            r_rght_shd <= 12'sd0;
            r_seen     <= 1'b0;
            r_fault    <= 1'b0;
            r_fcnt     <= 8'd0;
            r_shtdwn   <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 11'd1;
            r_seen   <= w_seen;
            r_fault  <= w_wrap ? 1'b0 : w_fault_now;
            r_fcnt   <= w_fcnt_nxt;
            r_shtdwn <= (w_state_nxt == SHTDWN);
            if (bus.spd_vld) begin
                r_lft_shd  <= bus.lft_spd;
                r_rght_shd <= bus.rght_spd;
            end
        end
    end

    pwm_dt #(.DEAD_TIME(DEAD_TIME), .BLANK(BLANK)) u_pwm_lft (
        .clk      (clk),
        .rst      (rst),
        .cnt      (r_cnt),
        .load     (w_wrap),
        .duty_in  (w_lft_duty),
        .en       (w_run_nxt),
        .ovr_i    (bus.OVR_I_lft),
        .pwm1     (bus.lft_PWM1),
        .pwm2     (bus.lft_PWM2),
        .ovr_qual (w_lft_q)
    );

    pwm_dt #(.DEAD_TIME(DEAD_TIME), .BLANK(BLANK)) u_pwm_rght (
        .clk      (clk),
        .rst      (rst),
        .cnt      (r_cnt),
        .load     (w_wrap),
        .duty_in  (w_rght_duty),
        .en       (w_run_nxt),
        .ovr_i    (bus.OVR_I_rght),
        .pwm1     (bus.rght_PWM1),
        .pwm2     (bus.rght_PWM2),
        .ovr_qual (w_rght_q)
    );

    assign bus.OVR_I_shtdwn = r_shtdwn;

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
// Module  : tb_mtr_drv
// Brief   : Randomized self-checking bench for mtr_drv against a period-level
//           reference model of the PWM, dead-time and fault rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mtr_drv;

    localparam int DT  = 32;
    localparam int BL  = 128;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mtr_drv_if bus();

    mtr_drv #(.DEAD_TIME(DT), .BLANK(BL), .OVR_LIM(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = idle, 1 = running, 2 = shut down
    int     m_cnt, m_mode, m_seen, m_fault, m_fcnt;
    int     m_duty [2];
    int     m_shd  [2];
    longint m_rise [2][2];
    bit     m_prev [2][2];
    bit     m_p    [2][2];
    bit     m_ovr  [2];
    longint cyc = 0;
    bit     mon_en = 1'b0;
    bit     q;
    logic [4:0] v_exp;

    function automatic int sat(input int v);
        if (v < 0)    return 0;
        if (v > 2047) return 2047;
        return v;
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_mode = 0; m_seen = 0; m_fault = 0; m_fcnt = 0;
        for (int m = 0; m < 2; m++) begin
            m_duty[m] = 1024;
            m_shd[m]  = 0;
            for (int k = 0; k < 2; k++) begin
                m_prev[m][k] = 1'b0;
                m_rise[m][k] = 0;
            end
        end
    endfunction

    function automatic int outs();
        logic [4:0] v;
        v = {bus.OVR_I_shtdwn, bus.lft_PWM1, bus.lft_PWM2, bus.rght_PWM1, bus.rght_PWM2};
        return int'(v);
    endfunction

    // Compare this cycle's outputs with the model, then advance the model by
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int m = 0; m < 2; m++) begin
                // index 0 = PWM1 (low-side phase), index 1 = PWM2
                m_p[m][0] = (m_mode == 1) && (m_cnt >= m_duty[m] + DT);
                m_p[m][1] = (m_mode == 1) && (m_cnt >= DT) && (m_cnt < m_duty[m]);
            end
            v_exp = {m_mode == 2, m_p[0][0], m_p[0][1], m_p[1][0], m_p[1][1]};
            chk("outputs", outs(), int'(v_exp));
            chk("lft_overlap",  int'(bus.lft_PWM1 & bus.lft_PWM2), 0);
            chk("rght_overlap", int'(bus.rght_PWM1 & bus.rght_PWM2), 0);

            m_ovr[0] = bus.OVR_I_lft;
            m_ovr[1] = bus.OVR_I_rght;
            q = 1'b0;
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_p[m][k] && !m_prev[m][k])
                        m_rise[m][k] = cyc;
                    if (m_p[m][k] && m_ovr[m] && (cyc - m_rise[m][k] >= BL))
                        q = 1'b1;
                    m_prev[m][k] = m_p[m][k];
                end
            end

            if (rst) begin
                model_reset();
            end else begin
                if (bus.spd_vld) begin
                    m_shd[0] = int'(bus.lft_spd);
                    m_shd[1] = int'(bus.rght_spd);
                    m_seen   = 1;
                end
                if (m_cnt == 2047) begin
                    m_duty[0] = sat(m_shd[0] + 1024);
                    m_duty[1] = sat(m_shd[1] + 1024);
                    if (m_fault != 0 || q)
                        m_fcnt = (m_fcnt < LIM) ? m_fcnt + 1 : LIM;
                    else
                        m_fcnt = 0;
                    m_fault = 0;
                    if (m_mode == 0 && m_seen != 0)
                        m_mode = 1;
                    else if (m_mode == 1 && m_fcnt >= LIM)
                        m_mode = 2;
                end else if (q) begin
                    m_fault = 1;
                end
                m_cnt = (m_cnt + 1) % 2048;
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int l, input int r);
        bus.lft_spd  = 12'(l);
        bus.rght_spd = 12'(r);
        bus.spd_vld  = 1'b1;
        tick();
        bus.spd_vld  = 1'b0;
    endtask

    // Advance to the next cycle whose count is 0 (bounded)
    task automatic to_wrap();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (m_cnt != 0 && k < 2100);
        chk("wrap_sync", m_cnt, 0);
    endtask

    task automatic run_periods(input int n);
        repeat (n) to_wrap();
    endtask

    int rst_at;

    initial begin
        bus.lft_spd    = 12'sd0;
        bus.rght_spd   = 12'sd0;
        bus.spd_vld    = 1'b0;
        bus.OVR_I_lft  = 1'b0;
        bus.OVR_I_rght = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        mon_en = 1'b1;
        chk("reset_outputs", outs(), 0);
        chk("reset_cnt", int'(dut.r_cnt), 0);
        rst = 1'b0;

        // Zero speed: 50% duty on both motors once running
        send(0, 0);
        run_periods(3);

        // Saturating speeds on both ends
        send(1200, -1100);
        run_periods(2);

        // Mid-period updates, sometimes back to back (last one wins)
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(100, 1800)) tick();
            send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
            if ($urandom_range(0, 1) == 1)
                send(int'($urandom_range(0, 2400)) - 1200, int'($urandom_range(0, 2400)) - 1200);
            to_wrap();
        end
        to_wrap();

        // Overcurrent: 3-period burst, one clean period, then 4 periods
        send(0, 0);
        to_wrap();
        bus.OVR_I_lft = 1'b1;
        run_periods(3);
        bus.OVR_I_lft = 1'b0;
        run_periods(1);
        chk("no_shtdwn_after_burst", int'(bus.OVR_I_shtdwn), 0);
        bus.OVR_I_lft = 1'b1;
        run_periods(4);
        chk("shtdwn_set", int'(bus.OVR_I_shtdwn), 1);
        chk("shtdwn_pwms_low", outs() & 15, 0);
        bus.OVR_I_lft = 1'b0;
        repeat (500) tick();
        chk("shtdwn_sticky", int'(bus.OVR_I_shtdwn), 1);

        // Reset from shutdown, mid-period
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_shtdwn_outs", outs(), 0);
        chk("rst_shtdwn_cnt", int'(dut.r_cnt), 0);

        // Right overcurrent only inside the blanking windows
        send(int'($urandom_range(0, 1600)) - 800, int'($urandom_range(0, 1600)) - 800);
        to_wrap();
        for (int i = 0; i < 4 * 2048; i++) begin
            bus.OVR_I_rght = (((m_cnt >= DT) && (m_cnt < DT + BL - 1)) ||
                              ((m_cnt >= m_duty[1] + DT) && (m_cnt < m_duty[1] + DT + BL - 1))) &&
                             ($urandom_range(0, 1) == 1);
            tick();
        end
        bus.OVR_I_rght = 1'b0;
        chk("blank_fault_cnt", int'(dut.r_fcnt), 0);
        chk("blank_no_shtdwn", int'(bus.OVR_I_shtdwn), 0);

        // Random speeds, sparse overcurrent pulses and one mid-period reset
        rst_at = int'($urandom_range(3000, 7000));
        for (int i = 0; i < 4 * 2048; i++) begin
            if (i == rst_at + 1) begin
                chk("rst_mid_outs", outs(), 0);
                chk("rst_mid_cnt", int'(dut.r_cnt), 0);
            end
            bus.OVR_I_lft  = ($urandom_range(0, 1499) == 0);
            bus.OVR_I_rght = ($urandom_range(0, 1499) == 0);
            bus.spd_vld    = ($urandom_range(0, 699) == 0) || (i == 10);
            bus.lft_spd    = 12'($urandom_range(0, 4095));
            bus.rght_spd   = 12'($urandom_range(0, 4095));
            rst            = (i == rst_at);
            tick();
        end
        bus.spd_vld    = 1'b0;
        bus.OVR_I_lft  = 1'b0;
        bus.OVR_I_rght = 1'b0;
        rst = 1'b0;
        run_periods(2);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
